// File: rtl/imem_arbiter.sv
// Two-port arbiter for the single-ported instruction RAM: fetch (F) has priority, debug (D) may lock.
// Optional D anti-starvation is enabled by defining IMEM_ARB_FAIRNESS_EN.
module imem_arbiter #(
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = 8,
    parameter int MAX_WAIT  = 4,
    parameter int ADDR_LEN  = 32,
    parameter int INSTR_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_req,
    input  logic [ADDR_LEN-1:0]  f_addr,
    output logic                 f_gnt,
    output logic                 f_rvalid,
    output logic [INSTR_LEN-1:0] f_rdata,
    output logic                 f_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic                 d_lock,
    input  logic [ADDR_LEN-1:0]  d_addr,
    input  logic [INSTR_LEN-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [INSTR_LEN-1:0] d_rdata,
    output logic                 d_err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [IDX_W-1:0]     mem_addr,
    output logic [INSTR_LEN-1:0] mem_wdata,
    input  logic [INSTR_LEN-1:0] mem_rdata,
    output logic                 locked
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_F    = 2'd1;
    localparam logic [1:0] S_D    = 2'd2;
    localparam logic [1:0] S_LOCK = 2'd3;

    if (IDX_W != $clog2(MEM_DEPTH) || MAX_WAIT < 1) begin : g_bad_params
        $error("imem_arbiter: inconsistent parameters");
    end

    logic [1:0] state, state_nxt;
    logic       in_lock, fair_win;
    logic       f_bad, d_bad;
    logic       rsp_err, rsp_we;

    assign in_lock = (state == S_LOCK);
    assign locked  = in_lock;

    // Misaligned or beyond the RAM: still granted, but the access is suppressed.
    assign f_bad = (f_addr[1:0] != 2'b00) || ((f_addr >> (IDX_W + 2)) != '0);
    assign d_bad = (d_addr[1:0] != 2'b00) || ((d_addr >> (IDX_W + 2)) != '0);

`ifdef IMEM_ARB_FAIRNESS_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    assign fair_win = ~in_lock & d_req & (wait_cnt == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (!d_req || d_gnt)
            wait_cnt <= '0;
        else if (wait_cnt != WAIT_W'(MAX_WAIT))
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign fair_win = 1'b0;
`endif

    assign f_gnt = ~in_lock & f_req & ~fair_win;
    assign d_gnt = in_lock ? d_req : (d_req & (~f_req | fair_win));

    assign mem_en    = (f_gnt & ~f_bad) | (d_gnt & ~d_bad);
    assign mem_we    = d_gnt & d_we & ~d_bad;
    assign mem_addr  = d_gnt ? d_addr[IDX_W+1:2] : f_addr[IDX_W+1:2];
    assign mem_wdata = d_wdata;

    always_comb begin
        state_nxt = S_IDLE;
        if (in_lock)
            state_nxt = d_lock ? S_LOCK : S_IDLE;
        else if (d_gnt && d_lock)
            state_nxt = S_LOCK;
        else if (f_gnt)
            state_nxt = S_F;
        else if (d_gnt)
            state_nxt = S_D;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_we   <= 1'b0;
        end else begin
            state    <= state_nxt;
            f_rvalid <= f_gnt;
            d_rvalid <= d_gnt;
            rsp_err  <= f_gnt ? f_bad : (d_gnt & d_bad);
            rsp_we   <= d_gnt & d_we;
        end
    end

    // RAM output is only forwarded to the port that owns this response slot.
    assign f_rdata = (f_rvalid & ~rsp_err) ? mem_rdata : '0;
    assign d_rdata = (d_rvalid & ~rsp_err & ~rsp_we) ? mem_rdata : '0;
    assign f_err   = f_rvalid & rsp_err;
    assign d_err   = d_rvalid & rsp_err;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural synchronous RAM.
// Fairness expectations follow IMEM_ARB_FAIRNESS_EN (MAX_WAIT=2 when defined).
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_gnt, f_rvalid, f_err;
    logic [31:0] f_addr, f_rdata;
    logic        d_req, d_we, d_lock, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, locked;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    imem_arbiter #(.MEM_DEPTH(256), .IDX_W(8), .MAX_WAIT(2), .ADDR_LEN(32), .INSTR_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            mem[2]    <= 32'h2001_0001;
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem_we ? 32'h0 : mem[mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (f_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_f_rvalid got %b want 0", f_rvalid); end
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_d_rvalid got %b want 0", d_rvalid); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
        n_checks++; if (f_err !== 1'b0 || d_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b want 00", f_err, d_err); end
    endtask

    task automatic test_fetch();
        f_req = 1'b1; f_addr = 32'h8; #1;
        n_checks++; if ({f_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL fetch_gnt got %b want 10", {f_gnt, d_gnt}); end
        n_checks++; if ({mem_en, mem_we} !== 2'b10) begin n_fail++; $display("FAIL fetch_mem_en_we got %b want 10", {mem_en, mem_we}); end
        n_checks++; if (mem_addr !== 8'd2) begin n_fail++; $display("FAIL fetch_mem_addr got %0d want 2", mem_addr); end
        cyc(); f_req = 1'b0; #1;
        n_checks++; if (f_rvalid !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid got %b want 1", f_rvalid); end
        n_checks++; if (f_rdata !== 32'h2001_0001) begin n_fail++; $display("FAIL fetch_rdata got %h want 20010001", f_rdata); end
        n_checks++; if (f_err !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_err_drv got %b%b want 00", f_err, d_rvalid); end
        cyc();
        n_checks++; if (f_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_rvalid_drop got %b want 0", f_rvalid); end
    endtask

    task automatic test_priority();
        logic [1:0] exp_g [3];
`ifdef IMEM_ARB_FAIRNESS_EN
        exp_g = '{2'b10, 2'b10, 2'b01};
`else
        exp_g = '{2'b10, 2'b10, 2'b10};
`endif
        f_req = 1'b1; f_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({f_gnt, d_gnt} !== exp_g[i]) begin
                n_fail++; $display("FAIL prio_gnt_c%0d got %b want %b", i, {f_gnt, d_gnt}, exp_g[i]);
            end
            cyc();
        end
        f_req = 1'b0; d_req = 1'b0; #1;
        n_checks++;
        if ({f_rvalid, d_rvalid} !== exp_g[2]) begin
            n_fail++; $display("FAIL prio_rvalid got %b want %b", {f_rvalid, d_rvalid}, exp_g[2]);
        end
        cyc();
    endtask

    task automatic test_lock();
        logic [31:0] wd [3];
        wd = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 3; i++) begin
            d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 32'(i * 4); d_wdata = wd[i];
            f_req = (i != 0); f_addr = 32'h4; #1;
            n_checks++; if ({f_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL lock_gnt_c%0d got %b want 01", i, {f_gnt, d_gnt}); end
            n_checks++; if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 8'(i)) begin
                n_fail++; $display("FAIL lock_mem_c%0d got en/we %b addr %0d want 11 %0d", i, {mem_en, mem_we}, mem_addr, i);
            end
            if (i != 0) begin
                n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked_c%0d got %b want 1", i, locked); end
                n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL lock_ack_c%0d got %b %h want 1 0", i, d_rvalid, d_rdata);
                end
            end
            cyc();
        end
        d_req = 1'b0; d_lock = 1'b0; d_we = 1'b0; f_req = 1'b1; #1;
        n_checks++; if ({locked, f_gnt, d_rvalid} !== 3'b101) begin n_fail++; $display("FAIL lock_release got %b want 101", {locked, f_gnt, d_rvalid}); end
        cyc(); #1;
        n_checks++; if ({locked, f_gnt, mem_addr} !== {2'b01, 8'd1}) begin
            n_fail++; $display("FAIL lock_after got %b %0d want 01 1", {locked, f_gnt}, mem_addr);
        end
        cyc(); f_req = 1'b0; #1;
        n_checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hB) begin n_fail++; $display("FAIL lock_readback got %b %h want 1 0000000b", f_rvalid, f_rdata); end
        cyc();
    endtask

    task automatic test_errors();
        f_req = 1'b1; f_addr = 32'h6; #1;
        n_checks++; if ({f_gnt, mem_en} !== 2'b10) begin n_fail++; $display("FAIL ferr_gnt_en got %b want 10", {f_gnt, mem_en}); end
        cyc(); f_req = 1'b0; #1;
        n_checks++; if ({f_rvalid, f_err} !== 2'b11 || f_rdata !== 32'h0) begin
            n_fail++; $display("FAIL ferr_rsp got %b %h want 11 0", {f_rvalid, f_err}, f_rdata);
        end
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hDEAD; #1;
        n_checks++; if ({d_gnt, mem_en, mem_we} !== 3'b100) begin n_fail++; $display("FAIL derr_gnt_en got %b want 100", {d_gnt, mem_en, mem_we}); end
        cyc(); d_req = 1'b0; d_we = 1'b0; #1;
        n_checks++; if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL derr_rsp got %b %h want 11 0", {d_rvalid, d_err}, d_rdata);
        end
        n_checks++; if (mem[0] !== 32'hA) begin n_fail++; $display("FAIL derr_no_write got %h want 0000000a", mem[0]); end
        cyc();
        n_checks++; if ({f_err, d_err, f_rvalid, d_rvalid} !== 4'b0) begin n_fail++; $display("FAIL err_clear got %b want 0000", {f_err, d_err, f_rvalid, d_rvalid}); end
    endtask

    task automatic test_reset_mid();
        f_req = 1'b1; f_addr = 32'h8; #1;
        n_checks++; if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt got %b want 1", f_gnt); end
        rst = 1'b1;
        cyc(); f_req = 1'b0; #1;
        n_checks++; if (f_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid got %b want 0", f_rvalid); end
        rst = 1'b0;
        cyc();
        n_checks++; if ({f_rvalid, locked} !== 2'b00) begin n_fail++; $display("FAIL rstmid_after got %b want 00", {f_rvalid, locked}); end
        d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        cyc();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rstlock_pre got %b want 1", locked); end
        rst = 1'b1; #1;
        n_checks++; if ({locked, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rstlock_async got %b want 00", {locked, d_rvalid}); end
        d_req = 1'b0; d_lock = 1'b0;
        cyc(); rst = 1'b0;
        cyc();
        n_checks++; if ({locked, d_rvalid, f_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rstlock_after got %b want 000", {locked, d_rvalid, f_rvalid}); end
    endtask

    initial begin
        rst = 1'b1;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
        cyc(); cyc();
        test_reset();
        rst = 1'b0;
        cyc();
        test_fetch();
        test_priority();
        test_lock();
        test_errors();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
